// File: rtl/tcm_axi_rd_burst_if.sv
// rtl/tcm_axi_rd_burst_if.sv - AR channel, TCM RAM read port and R-FIFO push/pop bundle
//
// Signals (directions as seen by the sequencer, modport slave):
//   axi_arvalid_i/araddr_i/arid_i/arlen_i/arburst_i  in   AR request
//   axi_arready_o                                    out  AR ready
//   ram_rd_o/ram_addr_o                              out  single-word RAM read
//   ram_data_i                                       in   RAM data, 1 cycle after ram_rd_o
//   fifo_push_o/fifo_data_o                          out  {id, last, data} beat into R FIFO
//   fifo_pop_i                                       in   R FIFO pop, returns one credit
//   busy_o                                           out  burst or beat in flight
// modport master is the environment side (AXI master, RAM, FIFO).

interface tcm_axi_rd_burst_if #(
  parameter int ID_W = 4
);
  logic              axi_arvalid_i;
  logic [31:0]       axi_araddr_i;
  logic [ID_W-1:0]   axi_arid_i;
  logic [7:0]        axi_arlen_i;
  logic [1:0]        axi_arburst_i;
  logic              axi_arready_o;
  logic              ram_rd_o;
  logic [31:0]       ram_addr_o;
  logic [31:0]       ram_data_i;
  logic              fifo_push_o;
  logic [ID_W+32:0]  fifo_data_o;
  logic              fifo_pop_i;
  logic              busy_o;

  modport slave (
    input  axi_arvalid_i, axi_araddr_i, axi_arid_i, axi_arlen_i, axi_arburst_i,
    input  ram_data_i, fifo_pop_i,
    output axi_arready_o, ram_rd_o, ram_addr_o, fifo_push_o, fifo_data_o, busy_o
  );

  modport master (
    output axi_arvalid_i, axi_araddr_i, axi_arid_i, axi_arlen_i, axi_arburst_i,
    output ram_data_i, fifo_pop_i,
    input  axi_arready_o, ram_rd_o, ram_addr_o, fifo_push_o, fifo_data_o, busy_o
  );
endinterface

// File: rtl/tcm_axi_rd_burst.sv
// rtl/tcm_axi_rd_burst.sv - AXI4 read-address sequencer feeding the TCM R-channel FIFO
//
// Ports:
//   clk_i  in  clock
//   rst_i  in  asynchronous active-high reset
//   bus    tcm_axi_rd_burst_if.slave: AR channel in, RAM read port out,
//          R FIFO push out / pop in, busy out
// One AR burst at a time is expanded into per-beat word reads (FIXED/INCR/WRAP).
// A beat is only issued while a FIFO credit is held, so a push never meets a full FIFO.

module tcm_axi_rd_burst #(
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int CRED_W     = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  tcm_axi_rd_burst_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  localparam logic [1:0]        BURST_FIXED = 2'd0;
  localparam logic [1:0]        BURST_WRAP  = 2'd2;
  localparam logic [CRED_W-1:0] CRED_MAX    = CRED_W'(FIFO_DEPTH);

  state_e            state_q;
  logic [31:0]       addr_q;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt_q;
  logic [1:0]        burst_q;
  logic [CRED_W-1:0] credit_q;
  logic              valid_q;
  logic [ID_W-1:0]   rid_q;
  logic              rlast_q;

  logic              issue;
  logic              wrap_ok;
  logic [31:0]       wrap_mask;
  logic [31:0]       addr_inc;
  logic [31:0]       addr_d;
  logic [CRED_W-1:0] credit_d;

  always_comb begin
    issue     = (state_q == ST_BURST) && (credit_q != '0);
    // Only power-of-two beat counts form a legal wrap window; anything else walks like INCR.
    wrap_ok   = (burst_q == BURST_WRAP) &&
                (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
    wrap_mask = ((32'(len_q) + 32'd1) << 2) - 32'd1;
    addr_inc  = addr_q + 32'd4;

    if (burst_q == BURST_FIXED) begin
      addr_d = addr_q;
    end else if (wrap_ok) begin
      addr_d = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    end else begin
      addr_d = addr_inc;
    end

    // Credit taken at issue, returned on pop; a pop with the FIFO already empty is ignored.
    credit_d = credit_q;
    if (issue && !bus.fifo_pop_i) begin
      credit_d = credit_q - CRED_W'(1);
    end else if (!issue && bus.fifo_pop_i && credit_q != CRED_MAX) begin
      credit_d = credit_q + CRED_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      burst_q    <= '0;
      credit_q   <= CRED_MAX;
      valid_q    <= 1'b0;
      rid_q      <= '0;
      rlast_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      valid_q  <= issue;
      if (issue) begin
        rid_q   <= id_q;
        rlast_q <= (beat_cnt_q == 8'd0);
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.axi_arvalid_i) begin
            addr_q     <= {bus.axi_araddr_i[31:2], 2'b00};
            id_q       <= bus.axi_arid_i;
            len_q      <= bus.axi_arlen_i;
            beat_cnt_q <= bus.axi_arlen_i;
            burst_q    <= bus.axi_arburst_i;
            state_q    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            if (beat_cnt_q == 8'd0) begin
              state_q <= ST_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
              addr_q     <= addr_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.axi_arready_o = (state_q == ST_IDLE);
  assign bus.ram_rd_o      = issue;
  assign bus.ram_addr_o    = addr_q;
  assign bus.fifo_push_o   = valid_q;
  // RAM data is combined with the registered beat tag in the cycle it arrives.
  assign bus.fifo_data_o   = valid_q ? {rid_q, rlast_q, bus.ram_data_i} : '0;
  assign bus.busy_o        = (state_q == ST_BURST) || valid_q;

endmodule

// File: tb/tb_tcm_axi_rd_burst.sv
// tb/tb_tcm_axi_rd_burst.sv - self-checking bench for tcm_axi_rd_burst

module tb_tcm_axi_rd_burst;

  localparam int ID_W = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  tcm_axi_rd_burst_if #(.ID_W(ID_W)) bus ();

  tcm_axi_rd_burst #(.ID_W(ID_W), .FIFO_DEPTH(2), .CRED_W(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: expected beat addresses of the open burst, credits, pending push.
  bit              m_burst;
  logic [31:0]     m_addrs[$];
  logic [ID_W-1:0] m_id;
  int              m_credit;
  bit              m_pend;
  logic [31:0]     m_pend_addr;
  bit              m_pend_last;
  logic [ID_W-1:0] m_pend_id;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic build_addrs(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int          n;
    logic [31:0] start, bytes, base;
    bit          wrap;
    n     = int'(len) + 1;
    start = {addr[31:2], 2'b00};
    bytes = 32'(n * 4);
    wrap  = (burst == 2'd2) && (n == 2 || n == 4 || n == 8 || n == 16);
    base  = start - (start % bytes);
    m_addrs.delete();
    for (int i = 0; i < n; i++) begin
      if (burst == 2'd0)  m_addrs.push_back(start);
      else if (wrap)      m_addrs.push_back(base + ((start - base + 32'(4 * i)) % bytes));
      else                m_addrs.push_back(start + 32'(4 * i));
    end
  endtask

  task automatic model_reset();
    m_burst  = 0;
    m_addrs.delete();
    m_credit = 2;
    m_pend   = 0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit arv, input logic [31:0] addr, input logic [ID_W-1:0] id,
                      input logic [7:0] len, input logic [1:0] burst, input bit pop);
    bit exp_rd, was_idle;
    bus.axi_arvalid_i = arv;
    bus.axi_araddr_i  = addr;
    bus.axi_arid_i    = id;
    bus.axi_arlen_i   = len;
    bus.axi_arburst_i = burst;
    bus.fifo_pop_i    = pop;
    bus.ram_data_i    = m_pend ? mem_word(m_pend_addr) : $urandom;
    @(negedge clk_i);
    exp_rd   = m_burst && (m_credit > 0);
    was_idle = !m_burst;
    check_val("arready", bus.axi_arready_o, was_idle);
    check_val("ram_rd", bus.ram_rd_o, exp_rd);
    if (exp_rd) check_val("ram_addr", bus.ram_addr_o, m_addrs[0]);
    check_val("fifo_push", bus.fifo_push_o, m_pend);
    if (m_pend) check_val("fifo_data", bus.fifo_data_o, {m_pend_id, m_pend_last, mem_word(m_pend_addr)});
    check_val("busy", bus.busy_o, m_burst || m_pend);

    if (exp_rd && !pop)                     m_credit--;
    else if (!exp_rd && pop && m_credit < 2) m_credit++;
    m_pend = exp_rd;
    if (exp_rd) begin
      m_pend_addr = m_addrs.pop_front();
      m_pend_last = (m_addrs.size() == 0);
      m_pend_id   = m_id;
      if (m_addrs.size() == 0) m_burst = 0;
    end
    if (arv && was_idle) begin
      m_burst = 1;
      m_id    = id;
      build_addrs(addr, len, burst);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i             = 1'b1;
    bus.axi_arvalid_i = 1'b0;
    bus.fifo_pop_i    = 1'b0;
    #1;
    check_val("rst_arready", bus.axi_arready_o, 1);
    check_val("rst_ram_rd", bus.ram_rd_o, 0);
    check_val("rst_push", bus.fifo_push_o, 0);
    check_val("rst_busy", bus.busy_o, 0);
    check_val("rst_ram_addr", bus.ram_addr_o, 0);
    check_val("rst_fifo_data", bus.fifo_data_o, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic idle_step(input bit pop);
    step(1'b0, $urandom, ID_W'($urandom), 8'($urandom), 2'($urandom), pop);
  endtask

  // Issues one AR then runs until the model says the burst and its last push are done.
  task automatic run_burst(input logic [31:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input int pop_pct);
    step(1'b1, addr, id, len, burst, $urandom_range(0, 99) < pop_pct);
    for (int c = 0; c < 400 && (m_burst || m_pend); c++) begin
      // arvalid with junk fields while busy must be ignored
      step(m_burst && ($urandom_range(0, 3) == 0), $urandom, ID_W'($urandom), 8'($urandom),
           2'($urandom), $urandom_range(0, 99) < pop_pct);
    end
    check_val("drain_timeout", {62'd0, m_burst, m_pend}, 0);
  endtask

  initial begin
    logic [7:0] len_opts[7];
    int         pct_opts[3];
    len_opts = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd15};
    pct_opts = '{30, 70, 100};

    rst_i             = 1'b1;
    bus.axi_arvalid_i = 1'b0;
    bus.axi_araddr_i  = '0;
    bus.axi_arid_i    = '0;
    bus.axi_arlen_i   = '0;
    bus.axi_arburst_i = '0;
    bus.ram_data_i    = '0;
    bus.fifo_pop_i    = 1'b0;
    model_reset();
    #1;
    apply_reset();

    repeat (3) idle_step(1'b1);

    run_burst(32'h0000_0100, 4'd1, 8'd3, 2'd1, 100);
    run_burst(32'h0000_0108, 4'd2, 8'd3, 2'd2, 100);
    run_burst(32'h0000_0108, 4'd3, 8'd2, 2'd2, 100);
    run_burst(32'h0000_0023, 4'd5, 8'd2, 2'd0, 100);
    run_burst(32'hFFFF_FFF8, 4'd6, 8'd3, 2'd1, 100);
    run_burst(32'h0000_0040, 4'd3, 8'd0, 2'd1, 100);

    // Credit exhaustion, one returned credit, then simultaneous issue+pop while draining.
    step(1'b1, 32'h0000_0400, 4'd7, 8'd7, 2'd1, 1'b0);
    repeat (5) idle_step(1'b0);
    idle_step(1'b1);
    idle_step(1'b0);
    idle_step(1'b0);
    for (int c = 0; c < 50 && (m_burst || m_pend); c++) idle_step(1'b1);
    check_val("bp_drain", {62'd0, m_burst, m_pend}, 0);

    // Reset while beat 2 of a len=7 burst is being issued.
    step(1'b1, 32'h0000_0200, 4'd7, 8'd7, 2'd1, 1'b1);
    idle_step(1'b1);
    apply_reset();
    run_burst(32'h0000_0300, 4'd2, 8'd3, 2'd1, 100);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) idle_step($urandom_range(0, 1) == 1);
      run_burst($urandom, ID_W'($urandom), len_opts[$urandom_range(0, 6)], 2'($urandom),
                pct_opts[$urandom_range(0, 2)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
